// File: rtl/crc_pkg.sv
// Shared types, polynomial presets and the bit-reflection helper for the CRC stream engine.
package crc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } crc_state_t;

  localparam logic [31:0] CRC32_POLY       = 32'h04C11DB7;
  localparam logic [15:0] CRC16_CCITT_POLY = 16'h1021;
  localparam logic [7:0]  CRC8_POLY        = 8'h07;

  // Reverses the low `width` bits of value; bits above width come back as zero.
  function automatic logic [63:0] reflect(input logic [63:0] value, input int width);
    logic [63:0] result;
    result = '0;
    for (int i = 0; i < 64; i++) begin
      if (i < width) result[6'(i)] = value[6'(width - 1 - i)];
    end
    return result;
  endfunction

endpackage

// File: rtl/crc_step.sv
// Unrolled LFSR update for one DATA_W-bit beat, byte lane 0 first, each byte MSB first
// (or LSB first when refin is set, which is the same as reflecting the byte).
module crc_step
  import crc_pkg::*;
#(
  parameter int CRC_W  = 32,
  parameter int DATA_W = 8
) (
  input  logic [CRC_W-1:0]  crc_in,
  input  logic [CRC_W-1:0]  poly,
  input  logic [DATA_W-1:0] data,
  input  logic              refin,
  output logic [CRC_W-1:0]  crc_out
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [CRC_W-1:0] lfsr_v;
  logic             fb;

  always_comb begin
    lfsr_v = crc_in;
    fb     = 1'b0;
    for (int j = 0; j < DATA_W; j++) begin
      fb     = lfsr_v[CRC_W-1] ^
               data[IDX_W'(refin ? ((j / 8) * 8 + (j % 8)) : ((j / 8) * 8 + 7 - (j % 8)))];
      lfsr_v = {lfsr_v[CRC_W-2:0], 1'b0} ^ (fb ? poly : '0);
    end
    crc_out = lfsr_v;
  end

endmodule

// File: rtl/crc_stream_engine.sv
// Streaming CRC engine: per-message latched configuration, one beat per cycle,
// registered result held on a valid/ready port until the consumer takes it.
module crc_stream_engine
  import crc_pkg::*;
#(
  parameter int CRC_W  = 32,
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [CRC_W-1:0]  cfg_poly_i,
  input  logic [CRC_W-1:0]  cfg_init_i,
  input  logic [CRC_W-1:0]  cfg_xorout_i,
  input  logic              cfg_refin_i,
  input  logic              cfg_refout_i,
  input  logic              start_i,
  input  logic              data_valid_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              data_last_i,
  output logic              data_ready_o,
  output logic              crc_valid_o,
  output logic [CRC_W-1:0]  crc_o,
  input  logic              crc_ready_i,
  output logic              busy_o
);

  crc_state_t       state, state_next;
  logic [CRC_W-1:0] lfsr;
  logic [CRC_W-1:0] poly_q;
  logic [CRC_W-1:0] xorout_q;
  logic             refin_q;
  logic             refout_q;
  logic [CRC_W-1:0] step_out;
  logic [CRC_W-1:0] crc_final;
  logic             beat_fire;

  crc_step #(
    .CRC_W (CRC_W),
    .DATA_W(DATA_W)
  ) u_step (
    .crc_in (lfsr),
    .poly   (poly_q),
    .data   (data_i),
    .refin  (refin_q),
    .crc_out(step_out)
  );

  assign crc_final = (refout_q ? CRC_W'(reflect(64'(step_out), CRC_W)) : step_out) ^ xorout_q;
  assign beat_fire = (state == RUN) && data_valid_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_i) state_next = RUN;
      RUN:     if (data_valid_i && data_last_i) state_next = DONE;
      DONE:    if (crc_ready_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Configuration is captured only on an accepted start so mid-message edits are inert.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr     <= '0;
      poly_q   <= '0;
      xorout_q <= '0;
      refin_q  <= 1'b0;
      refout_q <= 1'b0;
      crc_o    <= '0;
    end else begin
      if ((state == IDLE) && start_i) begin
        lfsr     <= cfg_init_i;
        poly_q   <= cfg_poly_i;
        xorout_q <= cfg_xorout_i;
        refin_q  <= cfg_refin_i;
        refout_q <= cfg_refout_i;
      end
      if (beat_fire) begin
        lfsr <= step_out;
        if (data_last_i) crc_o <= crc_final;
      end
    end
  end

  assign data_ready_o = (state == RUN);
  assign crc_valid_o  = (state == DONE);
  assign busy_o       = (state != IDLE);

endmodule

// File: tb/tb_crc_stream_engine.sv
// Directed bench: CRC-32/CRC-16 catalogue check values on shared-stream instances and a
// 32-bit-beat instance cross-checked against an independent reflected-table CRC-32 model.
module tb_crc_stream_engine;
  import crc_pkg::*;

  typedef struct {
    logic [31:0] init32;
    logic [31:0] xor32;
    logic        refl32;
    logic [15:0] init16;
    logic [15:0] xor16;
    logic        refl16;
    bit          gaps;
    bit          early;
    logic [31:0] exp32;
    logic [15:0] exp16;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] poly32, init32, xorout32;
  logic        refin32, refout32;
  logic [15:0] poly16, init16, xorout16;
  logic        refin16, refout16;
  logic        start, data_valid, data_last, crc_ready;
  logic [7:0]  data;
  logic        data_ready, crc_valid, busy;
  logic [31:0] crc32;
  logic        data_ready16, crc_valid16, busy16;
  logic [15:0] crc16;
  logic        w_start, w_valid, w_last, w_crc_ready;
  logic [31:0] w_data;
  logic        w_data_ready, w_crc_valid, w_busy;
  logic [31:0] w_crc;

  logic [7:0]  msg_buf [16];
  int          msg_len;
  int          compared = 0;
  int          mismatched = 0;
  vec_t        vecs [5];
  logic [31:0] exp_model;

  always #5 clk = ~clk;

  crc_stream_engine #(.CRC_W(32), .DATA_W(8)) dut8 (
    .clk_i(clk), .rst_i(rst),
    .cfg_poly_i(poly32), .cfg_init_i(init32), .cfg_xorout_i(xorout32),
    .cfg_refin_i(refin32), .cfg_refout_i(refout32),
    .start_i(start), .data_valid_i(data_valid), .data_i(data), .data_last_i(data_last),
    .data_ready_o(data_ready), .crc_valid_o(crc_valid), .crc_o(crc32),
    .crc_ready_i(crc_ready), .busy_o(busy)
  );

  crc_stream_engine #(.CRC_W(16), .DATA_W(8)) dut16 (
    .clk_i(clk), .rst_i(rst),
    .cfg_poly_i(poly16), .cfg_init_i(init16), .cfg_xorout_i(xorout16),
    .cfg_refin_i(refin16), .cfg_refout_i(refout16),
    .start_i(start), .data_valid_i(data_valid), .data_i(data), .data_last_i(data_last),
    .data_ready_o(data_ready16), .crc_valid_o(crc_valid16), .crc_o(crc16),
    .crc_ready_i(crc_ready), .busy_o(busy16)
  );

  crc_stream_engine #(.CRC_W(32), .DATA_W(32)) dut32 (
    .clk_i(clk), .rst_i(rst),
    .cfg_poly_i(poly32), .cfg_init_i(init32), .cfg_xorout_i(xorout32),
    .cfg_refin_i(refin32), .cfg_refout_i(refout32),
    .start_i(w_start), .data_valid_i(w_valid), .data_i(w_data), .data_last_i(w_last),
    .data_ready_o(w_data_ready), .crc_valid_o(w_crc_valid), .crc_o(w_crc),
    .crc_ready_i(w_crc_ready), .busy_o(w_busy)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // LSB-first reflected CRC-32, a different formulation from the engine's MSB-first LFSR.
  function automatic logic [31:0] modelCrc32(input int len);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < len; i++) begin
      c = c ^ {24'h0, msg_buf[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic loadCheckString();
    for (int i = 0; i < 9; i++) msg_buf[i] = 8'h31 + 8'(i);
    msg_len = 9;
  endtask

  task automatic setCrc32Cfg();
    poly32 = CRC32_POLY; init32 = 32'hFFFFFFFF; xorout32 = 32'hFFFFFFFF;
    refin32 = 1'b1; refout32 = 1'b1;
  endtask

  task automatic applyVec(input vec_t v);
    poly32 = CRC32_POLY; init32 = v.init32; xorout32 = v.xor32;
    refin32 = v.refl32; refout32 = v.refl32;
    poly16 = CRC16_CCITT_POLY; init16 = v.init16; xorout16 = v.xor16;
    refin16 = v.refl16; refout16 = v.refl16;
  endtask

  // Drives one message through the byte-wide instances, holds the result `hold` cycles, acks it.
  task automatic applyStimulus(input bit gaps, input bit scramble, input bit early, input int hold,
                               input logic [31:0] exp32, input logic [15:0] exp16, input bit chk16);
    int idle;
    crc_ready = early;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("ready_after_start", 64'(data_ready), 64'd1);
    checkOutput("busy_in_run", 64'(busy), 64'd1);
    for (int i = 0; i < msg_len; i++) begin
      if (gaps) begin
        idle = int'($urandom_range(0, 2));
        repeat (idle) begin
          data_valid = 1'b0; data = 8'hFF; data_last = 1'b1;
          @(posedge clk); #1;
        end
      end
      data_valid = 1'b1; data = msg_buf[i]; data_last = (i == msg_len - 1);
      @(posedge clk); #1;
      if (scramble && i == 0) begin
        poly32 = $urandom; init32 = $urandom; xorout32 = $urandom;
        refin32 = ~refin32; refout32 = ~refout32;
      end
    end
    data_valid = 1'b0; data_last = 1'b0;
    checkOutput("valid_after_last", 64'(crc_valid), 64'd1);
    checkOutput("crc32_result", 64'(crc32), 64'(exp32));
    if (chk16) begin
      checkOutput("valid16_after_last", 64'(crc_valid16), 64'd1);
      checkOutput("crc16_result", 64'(crc16), 64'(exp16));
    end
    for (int h = 0; h < hold; h++) begin
      start = (h == 0); data_valid = (h == 0); data_last = (h == 0); data = 8'h5A;
      @(posedge clk); #1;
      start = 1'b0; data_valid = 1'b0; data_last = 1'b0;
      checkOutput("hold_valid", 64'(crc_valid), 64'd1);
      checkOutput("hold_crc32", 64'(crc32), 64'(exp32));
      checkOutput("hold_ready_low", 64'(data_ready), 64'd0);
      if (chk16) checkOutput("hold_crc16", 64'(crc16), 64'(exp16));
    end
    crc_ready = 1'b1;
    @(posedge clk); #1;
    crc_ready = 1'b0;
    checkOutput("valid_dropped", 64'(crc_valid), 64'd0);
    checkOutput("idle_after_ack", 64'(busy), 64'd0);
    checkOutput("crc_kept", 64'(crc32), 64'(exp32));
  endtask

  task automatic runWide(input bit scramble, input logic [31:0] exp32);
    w_start = 1'b1;
    @(posedge clk); #1;
    w_start = 1'b0;
    for (int k = 0; k < msg_len / 4; k++) begin
      w_valid = 1'b1;
      w_data  = {msg_buf[4*k+3], msg_buf[4*k+2], msg_buf[4*k+1], msg_buf[4*k]};
      w_last  = (k == msg_len / 4 - 1);
      @(posedge clk); #1;
      if (scramble && k == 0) begin
        poly32 = $urandom; init32 = $urandom; xorout32 = $urandom;
        refin32 = ~refin32; refout32 = ~refout32;
      end
    end
    w_valid = 1'b0; w_last = 1'b0;
    checkOutput("wide_valid", 64'(w_crc_valid), 64'd1);
    checkOutput("wide_crc32", 64'(w_crc), 64'(exp32));
    w_crc_ready = 1'b1;
    @(posedge clk); #1;
    w_crc_ready = 1'b0;
    checkOutput("wide_idle", 64'(w_busy), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0; data_valid = 1'b0; data_last = 1'b0; data = 8'h00; crc_ready = 1'b0;
    w_start = 1'b0; w_valid = 1'b0; w_last = 1'b0; w_data = 32'h0; w_crc_ready = 1'b0;
    poly32 = '0; init32 = '0; xorout32 = '0; refin32 = 1'b0; refout32 = 1'b0;
    poly16 = '0; init16 = '0; xorout16 = '0; refin16 = 1'b0; refout16 = 1'b0;
    msg_len = 0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_ready", 64'(data_ready), 64'd0);
    checkOutput("reset_valid", 64'(crc_valid), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_crc32", 64'(crc32), 64'd0);
    checkOutput("reset_crc16", 64'(crc16), 64'd0);
    checkOutput("reset_wide_busy", 64'(w_busy), 64'd0);
    checkOutput("reset_wide_crc", 64'(w_crc), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    vecs[0] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b0, 32'hCBF43926, 16'h29B1};
    vecs[1] = '{32'hFFFFFFFF, 32'h00000000, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 32'h0376E6E7, 16'h31C3};
    vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 1'b1, 32'hFC891918, 16'hD64E};
    vecs[3] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 32'h340BC6D9, 16'h2189};
    vecs[4] = '{32'h00000000, 32'hFFFFFFFF, 1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 1'b0, 32'h765E7680, 16'h906E};

    loadCheckString();
    for (int v = 0; v < 5; v++) begin
      applyVec(vecs[v]);
      applyStimulus(vecs[v].gaps, 1'b0, vecs[v].early, 0, vecs[v].exp32, vecs[v].exp16, 1'b1);
    end

    // Backpressure with ignored start/data pulses in DONE, then a back-to-back message.
    applyVec(vecs[0]);
    applyStimulus(1'b0, 1'b0, 1'b0, 10, 32'hCBF43926, 16'h29B1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 32'hCBF43926, 16'h29B1, 1'b1);

    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      data_valid = 1'b1; data = msg_buf[i]; data_last = 1'b0;
      @(posedge clk); #1;
    end
    data_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("abort_ready", 64'(data_ready), 64'd0);
    checkOutput("abort_valid", 64'(crc_valid), 64'd0);
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_crc32", 64'(crc32), 64'd0);
    checkOutput("abort_crc16", 64'(crc16), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 32'hCBF43926, 16'h29B1, 1'b1);

    for (int m = 0; m < 64; m++) begin
      msg_len = 8;
      for (int b = 0; b < 8; b++) msg_buf[b] = 8'($urandom);
      exp_model = modelCrc32(8);
      setCrc32Cfg();
      applyStimulus(m[0], (m % 8) == 3, 1'b0, 0, exp_model, 16'h0, 1'b0);
      setCrc32Cfg();
      runWide((m % 8) == 5, exp_model);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/crc_stream_engine.md
# crc_stream_engine

Parametrised, streaming CRC engine that processes one DATA_W-bit beat per cycle over a valid/ready input stream and returns the final CRC on a valid/ready result port. It generalises the fixed bit-serial CRC-32 block to any CRC width and beat width. Polynomial, init value, input/output reflection and final XOR are runtime-configurable and latched per message. It sits between the host register interface (configuration, start) and the data path feeding message beats.

## Interface
- CRC_W, 32: CRC width in bits (8..64).
- DATA_W, 8: beat width in bits; must be a multiple of 8.
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- cfg_poly_i  in  CRC_W  polynomial, normal (MSB-first) notation, implicit x^CRC_W term.
- cfg_init_i  in  CRC_W  initial register value.
- cfg_xorout_i  in  CRC_W  final XOR value.
- cfg_refin_i  in  1  reflect each input byte.
- cfg_refout_i  in  1  reflect the final register before the XOR.
- start_i  in  1  begin a message; sampled only in IDLE.
- data_valid_i  in  1  beat valid.
- data_i  in  DATA_W  beat; byte lane 0 (bits 7:0) is processed first.
- data_last_i  in  1  beat is the last of the message.
- data_ready_o  out  1  engine accepts a beat.
- crc_valid_o  out  1  result valid.
- crc_o  out  CRC_W  final CRC.
- crc_ready_i  in  1  consumer accepts the result.
- busy_o  out  1  state != IDLE.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - data_ready_o=0, crc_valid_o=0.
  - start_i=1 latches all cfg_* into internal registers, loads lfsr<=cfg_init_i, and moves to RUN.
- RUN:
  - data_ready_o=1.
  - On data_valid_i&data_ready_o, lfsr<=step(lfsr, data_i).
  - If data_last_i is also set, crc_o<=finalize(step(...)) and the FSM moves to DONE.
  - Cycles without valid hold lfsr unchanged.
- DONE:
  - crc_valid_o=1, crc_o held stable, data_ready_o=0.
  - On crc_ready_i, return to IDLE. crc_o keeps its value; crc_valid_o drops.
- Step rule, per byte in lane order (lane 0 first):
  - byte is bit-reversed if refin.
  - Bits are processed MSB first: fb = lfsr[CRC_W-1]^bit; lfsr = (lfsr<<1) ^ (fb ? poly : 0), truncated to CRC_W.
- finalize(x) = (refout ? bitreverse_CRC_W(x) : x) ^ xorout.
- Ignored inputs, with no state change:
  - start_i outside IDLE.
  - data_valid_i outside RUN.
- cfg_* changes take effect only at the next accepted start. Mid-message changes have no effect.
- Messages are at least one beat long. Zero-length messages are not supported.

## Timing
- Reset: FSM=IDLE; data_ready_o=0, crc_valid_o=0, crc_o=0, busy_o=0; lfsr and cfg registers cleared to 0.
- Reset asserted mid-message aborts the message. No result is produced, and the FSM is in IDLE on the cycle after rst_i.
- start accepted in cycle N: data_ready_o=1 from N+1.
- Throughput: one beat per cycle, with no bubbles under continuous valid.
- Last beat accepted in cycle N: crc_valid_o=1 and crc_o valid in N+1.
- Result handshake completes in cycle M (crc_ready_i=1 while crc_valid_o=1): IDLE from M+1. A new start is accepted no earlier than M+1.
- crc_ready_i may be held high early. The minimum DONE dwell is then 1 cycle.
- No combinational path from any input to any output. All outputs are registered or decoded from the FSM register.

## Structure
- Shared package crc_pkg holds:
  - state enum crc_state_t {IDLE, RUN, DONE}.
  - a reflect function.
  - preset constants: CRC32_POLY=32'h04C11DB7, CRC16_CCITT_POLY=16'h1021, CRC8_POLY=8'h07.
- One combinational sub-module, crc_step, is parametrised by CRC_W and DATA_W. It is a DATA_W-bit unrolled LFSR update with a refin input.
- The top level holds the FSM, cfg registers and finalize.

## Test plan
- CRC-32 setup: CRC_W=32, DATA_W=8, poly 04C11DB7, init FFFFFFFF, refin=refout=1, xorout FFFFFFFF.
  - Stimulus: ASCII "123456789", continuous valid.
  - Required: crc_o=32'hCBF43926, one cycle after the last beat.
- CRC-32/MPEG-2 setup: same as above but refin=refout=0, xorout 0.
  - Stimulus: "123456789", with data_valid_i randomly deasserted between beats.
  - Required: crc_o=32'h0376E6E7.
- CRC-16/CCITT-FALSE setup: CRC_W=16, poly 1021, init FFFF, no reflection, xorout 0.
  - Stimulus: "123456789".
  - Required: crc_o=16'h29B1.
- DATA_W=32 instance vs DATA_W=8 instance, CRC-32 config.
  - Stimulus: 64 random 8-byte messages, fed to both.
  - Required: identical crc_o. Also change cfg_* mid-message and check the result is unchanged.
- Output backpressure and ignored inputs:
  - Hold crc_ready_i=0 for 10 cycles: crc_valid_o and crc_o stay stable.
  - start_i and data_valid_i pulsed in DONE are ignored.
  - A back-to-back message started at M+1 yields the correct CRC.
- Reset mid-message: assert rst_i after 4 of 9 beats.
  - Required: all outputs 0 the next cycle.
  - A new "123456789" message then yields 32'hCBF43926.
